// File: rtl/reg7_arb_pkg.sv
// Shared types and helpers for the reg7 write arbiter.
// The lock feature is enabled by defining REG7_ARB_LOCK_EN. The LOCKED encoding
// is always present in the enum so that every build shares one state type.
package reg7_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT    = 2'd1,
      LOCKED = 2'd2
   } arb_state_e;

   localparam int NREQ_DEF  = 4;
   localparam int DEPTH_DEF = 4;
   localparam int WIDTH_DEF = 7;

   // Round-robin pick: first set bit of req scanning from (last_gnt+1) mod nreq.
   // The scan runs from the far end down so that the nearest candidate is the
   // last one assigned, which avoids an early loop exit. If no bit is set the
   // function returns last_gnt; callers only use the result when req is non-zero.
   function automatic int rr_winner(input logic [7:0] req,
                                    input int         last_gnt,
                                    input int         nreq);
      int win;
      int idx;
      win = last_gnt;
      for (int k = nreq; k >= 1; k--) begin
         idx = (last_gnt + k) % nreq;
         if (req[idx[2:0]]) begin
            win = idx;
         end
      end
      return win;
   endfunction

endpackage : reg7_arb_pkg

// File: rtl/reg7_bank.sv
// DEPTH x WIDTH register bank: one synchronous write port, one combinational
// read port, and an asynchronous active-low clear of every entry.
module reg7_bank
   import reg7_arb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int AW    = $clog2(DEPTH)
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Next bank contents: only the addressed entry changes, and only when enabled.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end else begin
         mem_d = mem_q;
      end
   end

   // Bank storage with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : reg7_bank

// File: rtl/reg7_write_arbiter.sv
// Round-robin write arbiter in front of a shared register bank.
// Each granted write takes two cycles (IDLE -> GNT -> IDLE). When the macro
// REG7_ARB_LOCK_EN is defined, a lock input lets the granted requester stay in
// a LOCKED state and write on every edge until it releases the lock.
module reg7_write_arbiter
   import reg7_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ*$clog2(DEPTH)-1:0] wr_addr,
   input  logic [NREQ*WIDTH-1:0]       wr_data,
`ifdef REG7_ARB_LOCK_EN
   input  logic [NREQ-1:0]             lock,
`endif
   output logic [NREQ-1:0]             gnt,
   output logic                        busy,
   input  logic [$clog2(DEPTH)-1:0]    rd_addr,
   output logic [WIDTH-1:0]            rd_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [IW-1:0]    last_q, last_d;
   logic [IW-1:0]    gidx_q, gidx_d;
   logic [IW-1:0]    win_s;
   logic             we_s;
   logic [AW-1:0]    waddr_s;
   logic [WIDTH-1:0] wdata_s;

   // Winner for the next grant and the granted requester's write slice.
   always_comb begin
      win_s   = IW'(rr_winner(8'(req), int'(last_q), NREQ));
      waddr_s = wr_addr[int'(gidx_q)*AW +: AW];
      wdata_s = wr_data[int'(gidx_q)*WIDTH +: WIDTH];
   end

   // Next-state, grant and bank write-enable decode.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      gidx_d  = gidx_q;
      we_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d        = GNT;
               gnt_d          = '0;
               gnt_d[win_s]   = 1'b1;
               last_d         = win_s;
               gidx_d         = win_s;
            end else begin
               gnt_d = '0;
            end
         end
         GNT: begin
            we_s = 1'b1;
`ifdef REG7_ARB_LOCK_EN
            if (lock[gidx_q]) begin
               state_d = LOCKED;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
`else
            state_d = IDLE;
            gnt_d   = '0;
`endif
         end
`ifdef REG7_ARB_LOCK_EN
         LOCKED: begin
            // The release edge still writes; other requesters wait until IDLE.
            we_s = 1'b1;
            if (lock[gidx_q]) begin
               state_d = LOCKED;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Arbiter state registers; last grant resets so requester 0 wins first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(NREQ - 1);
         gidx_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         gidx_q  <= gidx_d;
      end
   end

   assign gnt  = gnt_q;
   assign busy = (state_q != IDLE);

   reg7_bank #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_bank (
      .clk   (clk),
      .rst_n (reset),
      .we    (we_s),
      .waddr (waddr_s),
      .wdata (wdata_s),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule : reg7_write_arbiter

// File: doc/reg7_write_arbiter.md
REG7_WRITE_ARBITER -- requirements
Module: reg7_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter DEPTH, default 4: number of entries in the shared register bank, power of two.
REQ-003 Parameter WIDTH, default 7: bits per bank entry.
REQ-004 The port list SHALL be as follows.
- clk  input  1: single clock; all state updates on its rising edge.
- reset  input  1: asynchronous, active-low reset.
- req  input  NREQ: per-requester write request, level.
- wr_addr  input  NREQ*log2(DEPTH): packed per-requester target entry; requester i uses slice i.
- wr_data  input  NREQ*WIDTH: packed per-requester write data; requester i uses slice i.
- gnt  output  NREQ: one-hot-or-zero write grant, registered.
- busy  output  1: high whenever the state is not IDLE.
- rd_addr  input  log2(DEPTH): read select.
- rd_data  output  WIDTH: bank[rd_addr], combinational read.

Function
REQ-005 The block SHALL implement FSM states IDLE and GNT, plus LOCKED when the lock feature is compiled in.
REQ-006 In IDLE with any req bit high, the block SHALL select the winner round-robin starting at index (last_gnt+1) mod NREQ, enter GNT and assert gnt[winner] from the next cycle.
REQ-007 In GNT, the rising edge that ends the cycle SHALL write wr_data slice into bank[wr_addr slice] of the granted requester, and the next state SHALL be IDLE.
- Each write therefore costs 2 cycles.
- A continuously requesting requester is never granted in back-to-back cycles.
REQ-008 Grant latency from req rising (sampled in IDLE) to gnt high SHALL be exactly 1 cycle.
REQ-009 The requester SHALL hold req, wr_addr and wr_data stable through its gnt cycle and deassert req before the following edge.
- A req still high in IDLE is treated as a new request.
REQ-010 last_gnt SHALL update to the winner on every IDLE->GNT transition; it SHALL NOT change otherwise.
REQ-011 With simultaneous requests, all NREQ requesters SHALL each be granted once within 2*NREQ cycles; no requester waits more than NREQ grants.
REQ-012 In IDLE with req = 0, gnt SHALL stay 0, the state SHALL stay IDLE and the bank SHALL be unchanged.
REQ-013 A req rising while another requester is in GNT SHALL be arbitrated at the next IDLE, not preempt.
REQ-014 rd_data SHALL reflect the new value starting the cycle after the write edge; reading the entry being written in the GNT cycle returns the old value.

Reset
REQ-015 While reset is low, asynchronously:
- state = IDLE
- gnt = 0
- busy = 0
- all bank entries = 0
- last_gnt = NREQ-1, so requester 0 has first priority.
REQ-016 Reset asserted during GNT or LOCKED SHALL abort the pending write; the bank entry SHALL read 0 after reset.

Configuration
REQ-017 When macro REG7_ARB_LOCK_EN is defined, the block SHALL add input lock[NREQ] and the LOCKED state.
- In GNT, if lock[granted] is high, the next state SHALL be LOCKED instead of IDLE.
- In LOCKED, gnt stays on the same requester and a write occurs on every edge.
- The block SHALL exit LOCKED to IDLE at the first edge where lock[granted] is low; that cycle still writes.
- Other requests wait.
REQ-018 Without REG7_ARB_LOCK_EN, the lock port and LOCKED state SHALL be absent, and GNT always returns to IDLE.

Structure
REQ-019 A shared package reg7_arb_pkg SHALL hold:
- the state enum (IDLE, GNT, LOCKED)
- default constants NREQ_DEF=4, DEPTH_DEF=4, WIDTH_DEF=7
- a round-robin helper function returning the winner index from req and last_gnt.
REQ-020 The bank SHALL be a sub-module reg7_bank with:
- DEPTH x WIDTH registers
- one write port (we, waddr, wdata)
- asynchronous active-low clear
- a combinational read port.
The arbiter drives we only in GNT/LOCKED.

Verification
REQ-021 Reset release, req=0 for 10 cycles -> gnt=0, busy=0, rd_data=0 for every rd_addr.
REQ-022 req=4'b0001, addr0=2, data0=7'h2A, dropped after gnt -> gnt=0001 on cycle 2, bank[2]=7'h2A on cycle 3, busy high exactly 1 cycle.
REQ-023 req=4'b1111 held (re-raised each IDLE), distinct addr/data -> grant order 0,1,2,3,0, one gnt every 2 cycles, no back-to-back grant to the same requester.
REQ-024 Requester 1 in GNT while requester 3 raises req -> requester 3 granted in the GNT after the next IDLE; requester 1 write unaffected.
REQ-025 Reset pulled low mid-GNT with data 7'h7F to entry 1 -> gnt=0 immediately, bank[1]=0 after release.
REQ-026 With REG7_ARB_LOCK_EN, requester 2 holds lock for 3 cycles writing 7'h01, 7'h02, 7'h03 to entry 0 while req0 high -> bank[0]=7'h03; requester 0 granted only after the LOCKED->IDLE transition.
